dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 128: number of data words stored.
REQ-002 Parameter AW, default 7: address width; 2**AW SHALL equal DEPTH.
REQ-003 Parameter DW, default 32: data word width.
REQ-004 Parameter CW, default 16: width of each access counter.
REQ-005 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 Port CEN  input  1: chip enable, active-low.
REQ-008 Port WEN  input  1: write enable, active-low.
REQ-009 Port OEN  input  1: output enable, active-low.
REQ-010 Port A  input  AW: word address.
REQ-011 Port Data2Mem  input  DW: write data.
REQ-012 Port ReadDataMem  output  DW: read data.
REQ-013 Port ready  output  1: high once the post-reset memory clear is complete.
REQ-014 Port rd_cnt  output  CW: count of accepted reads.
REQ-015 Port wr_cnt  output  CW: count of accepted writes.
REQ-016 Port err  output  1: sticky protocol-error flag.

Function
REQ-017 Block SHALL be the data-memory responder to the processor's CEN/WEN/OEN/A/Data2Mem initiator port, holding DEPTH x DW words.
REQ-018 State machine SHALL have two states: CLEAR and SERVE.
REQ-019 In CLEAR, each cycle: mem[clr_ptr] <= 0, then clr_ptr increments by 1.
REQ-020 Cycle in CLEAR with clr_ptr == DEPTH-1: writes that last word, then enters SERVE; ready = 1 from the following cycle.
REQ-021 ready SHALL equal 1 exactly when state is SERVE; first high DEPTH rising edges after rst_n deasserts.
REQ-022 Read access: state SERVE, CEN=0, OEN=0, WEN=1.
REQ-023 Read data SHALL be combinational (zero latency): ReadDataMem = mem[A] during a read access; 0 at all other times.
REQ-024 Write access: state SERVE, CEN=0, WEN=0; mem[A] <= Data2Mem on the rising edge. OEN is ignored for the write itself.
REQ-025 A read of an address written on the previous edge SHALL return the new data.
REQ-026 CEN=1 SHALL suppress all accesses, counting and error detection regardless of WEN/OEN.
REQ-027 rd_cnt SHALL increment by 1 per rising edge on which a read access is present.
REQ-028 wr_cnt SHALL increment by 1 per rising edge on which a write access is present.
REQ-029 Counters SHALL saturate at 2**CW-1 with no wrap-around.
REQ-030 err SHALL set on any edge with CEN=0, WEN=0, OEN=0 (conflicting write+output enable); the write still completes and wr_cnt still increments.
REQ-031 err SHALL set on any edge in CLEAR with CEN=0; that access is dropped with no memory change and no count.
REQ-032 err SHALL clear only on reset.
REQ-033 All AW-bit addresses are valid; no out-of-range condition exists.

Reset
REQ-034 rst_n low SHALL immediately force: state=CLEAR, clr_ptr=0, ready=0, rd_cnt=0, wr_cnt=0, err=0, ReadDataMem=0.
REQ-035 Reset asserted mid-CLEAR or mid-SERVE SHALL restart the full clear; no memory contents survive reset.

Verification
REQ-036 Release reset, hold CEN=1 -> ready=0 for 128 edges, ready=1 after edge 128; reading any address then returns 0.
REQ-037 SERVE: write 0xDEADBEEF to A=5, then read A=5 next cycle -> ReadDataMem=0xDEADBEEF same cycle; wr_cnt=1, rd_cnt=1, err=0.
REQ-038 SERVE: CEN=0, WEN=0, OEN=0, A=127, data 0x12345678 -> err=1 after the edge; mem[127]=0x12345678; wr_cnt increments.
REQ-039 During CLEAR, issue a write to A=3 at cycle 10 -> err=1; after ready, read A=3 returns 0; wr_cnt=0.
REQ-040 Preload wr_cnt to 0xFFFE via 65534 writes, then 3 more writes -> wr_cnt holds 0xFFFF.
REQ-041 Pulse rst_n low at clear cycle 60 and at a SERVE cycle after writes -> outputs zero immediately; ready reasserts 128 edges after release; earlier data reads 0.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: clears its DEPTH x DW array after every reset, then serves
// zero-latency reads and edge-triggered writes with saturating access counters.
module dmem_resp #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] Data2Mem,
    output logic [DW-1:0] ReadDataMem,
    output logic          ready,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] wr_cnt,
    output logic          err
);

    typedef enum logic {CLEAR, SERVE} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          clr_last;
    logic          rd_acc;
    logic          wr_acc;
    logic          err_set;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    endfunction

    always_comb begin
        state_next = state;
        clr_last   = (state == CLEAR) && (clr_ptr == AW'(DEPTH - 1));
        ready      = (state == SERVE);
        rd_acc     = (state == SERVE) && !CEN && !OEN && WEN;
        wr_acc     = (state == SERVE) && !CEN && !WEN;
        // Write+output conflict is flagged in any state; any enabled access during CLEAR is too.
        err_set    = !CEN && ((!WEN && !OEN) || (state == CLEAR));
        if (clr_last)
            state_next = SERVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_ptr <= clr_ptr + AW'(1);
            if (rd_acc)
                rd_cnt <= sat_inc(rd_cnt);
            if (wr_acc)
                wr_cnt <= sat_inc(wr_cnt);
            if (err_set)
                err <= 1'b1;
        end
    end

    // Array has no reset of its own; the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_ptr] <= '0;
        else if (wr_acc)
            mem[A] <= Data2Mem;
    end

    assign ReadDataMem = rd_acc ? mem[A] : '0;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: table vectors, reset/clear corner sequences,
// counter saturation and randomized traffic against a behavioural memory model.
module tb_dmem_resp;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int MAXC  = 65535;

    logic          clk;
    logic          rst_n;
    logic          CEN;
    logic          WEN;
    logic          OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] Data2Mem;
    logic [DW-1:0] ReadDataMem;
    logic          ready;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic          err;

    dmem_resp #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .CEN        (CEN),
        .WEN        (WEN),
        .OEN        (OEN),
        .A          (A),
        .Data2Mem   (Data2Mem),
        .ReadDataMem(ReadDataMem),
        .ready      (ready),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: memory reads as zero after reset; accesses count only
    // once DEPTH edges have elapsed since reset release.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_edges;
    int            m_rd;
    int            m_wr;
    bit            m_err;

    int unsigned   tests;
    int unsigned   fails;
    logic [DW-1:0] last_rdata;

    typedef struct {
        logic          cen;
        logic          wen;
        logic          oen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rdata;
        logic [CW-1:0] exp_rd;
        logic [CW-1:0] exp_wr;
        logic          exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 50)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_edges = 0;
        m_rd    = 0;
        m_wr    = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge(input logic c, input logic w, input logic o,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!c) begin
            if (m_edges < DEPTH) begin
                m_err = 1'b1;
            end else if (!w) begin
                m_mem[a] = d;
                if (m_wr < MAXC) m_wr++;
                if (!o) m_err = 1'b1;
            end else if (!o) begin
                if (m_rd < MAXC) m_rd++;
            end
        end
        if (m_edges < DEPTH) m_edges++;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic c, input logic w, input logic o,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] exp_rdata;
        CEN      = c;
        WEN      = w;
        OEN      = o;
        A        = a;
        Data2Mem = d;
        #3;
        exp_rdata  = (m_edges >= DEPTH && !c && !o && w) ? m_mem[a] : '0;
        last_rdata = ReadDataMem;
        chk("rdata", ReadDataMem, exp_rdata);
        @(posedge clk);
        model_edge(c, w, o, a, d);
        #1;
        chk("ready", 32'(ready), 32'(m_edges >= DEPTH));
        chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
        chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // Asserts reset mid-cycle with whatever inputs are applied, checks the
    // asynchronous clear, then releases it just after the next rising edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", ReadDataMem, 32'd0);
        model_reset();
        CEN = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic finish_clear();
        for (int i = 0; i < DEPTH + 2 && m_edges < DEPTH; i++)
            cycle(1'b1, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; Data2Mem = '0;
        model_reset();

        //         cen   wen   oen   a       d              rdata          rd     wr     err
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 7'd5,   32'hDEADBEEF, 32'h0,         16'd0, 16'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 7'd5,   32'h0,        32'hDEADBEEF,  16'd1, 16'd1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 7'd0,   32'h0,        32'h0,         16'd2, 16'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 7'd64,  32'h0,        32'h0,         16'd3, 16'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 7'd5,   32'h0,        32'h0,         16'd3, 16'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 7'd6,   32'hFFFFFFFF, 32'h0,         16'd3, 16'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 7'd5,   32'h0,        32'h0,         16'd3, 16'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 7'd6,   32'h0,        32'h0,         16'd4, 16'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 7'd3,   32'h33333333, 32'h0,         16'd4, 16'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 7'd127, 32'h12345678, 32'h0,         16'd4, 16'd3, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 7'd127, 32'h0,        32'h12345678,  16'd5, 16'd3, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 7'd3,   32'h0,        32'h33333333,  16'd6, 16'd3, 1'b1};

        // Power-up reset and clear with CEN held high
        @(posedge clk);
        #1;
        chk("init_ready", 32'(ready), 32'd0);
        chk("init_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("init_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        chk("init_rdata", ReadDataMem, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
            if (i == DEPTH - 2) chk("ready_edge127", 32'(ready), 32'd0);
        end
        chk("ready_edge128", 32'(ready), 32'd1);

        // Table vectors in SERVE
        foreach (vecs[i]) begin
            cycle(vecs[i].cen, vecs[i].wen, vecs[i].oen, vecs[i].a, vecs[i].d);
            chk("vec_rdata", last_rdata, vecs[i].exp_rdata);
            chk("vec_rd_cnt", 32'(rd_cnt), 32'(vecs[i].exp_rd));
            chk("vec_wr_cnt", 32'(wr_cnt), 32'(vecs[i].exp_wr));
            chk("vec_err", 32'(err), 32'(vecs[i].exp_err));
        end

        // Access during CLEAR is dropped and flagged
        do_reset();
        for (int i = 1; i < 10; i++)
            cycle(1'b1, 1'b0, 1'b0, 7'd3, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 7'd3, 32'hCAFE0003);
        chk("clear_wr_err", 32'(err), 32'd1);
        finish_clear();
        cycle(1'b0, 1'b1, 1'b0, 7'd3, 32'h0);
        chk("clear_wr_dropped", last_rdata, 32'd0);
        chk("clear_wr_cnt", 32'(wr_cnt), 32'd0);

        // Reset mid-clear, then mid-serve with a live read applied
        do_reset();
        for (int i = 0; i < 60; i++)
            cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
        chk("ready_after_midclear", 32'(ready), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 7'd10, 32'hA0A0A0A0);
        cycle(1'b0, 1'b0, 1'b1, 7'd11, 32'hB1B1B1B1);
        cycle(1'b0, 1'b1, 1'b0, 7'd10, 32'h0);
        chk("pre_rst_rdata", ReadDataMem, 32'hA0A0A0A0);
        do_reset();
        finish_clear();
        cycle(1'b0, 1'b1, 1'b0, 7'd10, 32'h0);
        chk("post_rst_a10", last_rdata, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 7'd11, 32'h0);
        chk("post_rst_a11", last_rdata, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] ra;
            if (i % 1000 == 999) do_reset();
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 4) != 0),
                  ra, $urandom);
        end

        // Write counter saturation
        do_reset();
        finish_clear();
        for (int i = 0; i < 65534; i++)
            cycle(1'b0, 1'b0, 1'b1, AW'($urandom), $urandom);
        chk("wr_cnt_fffe", 32'(wr_cnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1, AW'($urandom), $urandom);
        chk("wr_cnt_sat", 32'(wr_cnt), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
